// File: rtl/z16_alu_pkg.sv
// Shared types for the Z16 multi-cycle ALU: opcodes, handshake FSM states
// and the helper that tells iterative opcodes apart from single-cycle ones.
package z16_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_MUL = 4'h2,
    OP_DIV = 4'h3,
    OP_OR  = 4'h4,
    OP_AND = 4'h5,
    OP_XOR = 4'h6,
    OP_SHL = 4'h7,
    OP_SHR = 4'h8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iter(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/z16_alu_iter_unit.sv
// Shared iterative datapath: shift-add multiply and restoring divide,
// one bit per cycle for WIDTH cycles. The final step's result is presented alongside done_o.
import z16_alu_pkg::*;

module z16_alu_iter_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // acc: product (MUL) or partial remainder (DIV); x: multiplicand/divisor;
  // y: multiplier shifting right (MUL) or dividend shifting into quotient (DIV)
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, div_q, div_d;
  logic [WIDTH:0]   rem_sh_s, diff_s;

  // Next-state for one iteration step or a fresh start
  always_comb begin
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    div_d    = div_q;
    rem_sh_s = {acc_q, y_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, x_q};
    if (start_i) begin
      acc_d  = {WIDTH{1'b0}};
      x_d    = a_i;
      y_d    = b_i;
      cnt_d  = CNT_MAX;
      busy_d = 1'b1;
      div_d  = (op_i == OP_DIV);
    end else if (busy_q) begin
      if (div_q) begin
        if (!diff_s[WIDTH]) begin
          acc_d = diff_s[WIDTH-1:0];
          y_d   = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh_s[WIDTH-1:0];
          y_d   = {y_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (y_q[0]) begin
          acc_d = acc_q + x_q;
        end else begin
          acc_d = acc_q;
        end
        x_d = {x_q[WIDTH-2:0], 1'b0};
        y_d = {1'b0, y_q[WIDTH-1:1]};
      end
      if (cnt_q == CNT_ZERO) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= {WIDTH{1'b0}};
      x_q    <= {WIDTH{1'b0}};
      y_q    <= {WIDTH{1'b0}};
      cnt_q  <= CNT_ZERO;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      div_q  <= div_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CNT_ZERO);
  assign prod_quo_o = div_q ? y_d : acc_d;
  assign rem_o      = acc_d;

endmodule

// File: rtl/z16_alu_mc.sv
// Z16 multi-cycle ALU top: valid/ready handshake FSM, single-cycle op mux, output registers.
// Optional macro Z16_ALU_REM_EN adds the o_rem divide-remainder output.
import z16_alu_pkg::*;

module z16_alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic [3:0]       i_ctrl,
  output logic             o_valid,
  input  logic             i_ready,
`ifdef Z16_ALU_REM_EN
  output logic [WIDTH-1:0] o_rem,
`endif
  output logic [WIDTH-1:0] o_data,
  output logic             o_dbz
);

  localparam logic [WIDTH-1:0] SH_LIM = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  op_e              op_q, op_d, op_in_s;
  logic [WIDTH-1:0] data_q, data_d, alu_res_s;
  logic             dbz_q, dbz_d, dbz_pend_q, dbz_pend_d;
  logic             iter_start_s, iter_done_s, iter_busy_unused_s;
  logic [WIDTH-1:0] iter_res_s;
`ifdef Z16_ALU_REM_EN
  logic [WIDTH-1:0] rem_q, rem_d, iter_rem_s;
`else
  logic [WIDTH-1:0] iter_rem_unused_s;
`endif

  assign op_in_s = op_e'(i_ctrl);

  z16_alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk_i      (i_clk),
    .rst_n_i    (i_rst_n),
    .start_i    (iter_start_s),
    .op_i       (op_in_s),
    .a_i        (i_data_a),
    .b_i        (i_data_b),
    .busy_o     (iter_busy_unused_s),
    .done_o     (iter_done_s),
    .prod_quo_o (iter_res_s),
`ifdef Z16_ALU_REM_EN
    .rem_o      (iter_rem_s)
`else
    .rem_o      (iter_rem_unused_s)
`endif
  );

  // Single-cycle result; B is the left operand, unlisted opcodes fall back to ADD
  always_comb begin
    alu_res_s = i_data_b + i_data_a;
    case (op_in_s)
      OP_ADD:  alu_res_s = i_data_b + i_data_a;
      OP_SUB:  alu_res_s = i_data_b - i_data_a;
      OP_OR:   alu_res_s = i_data_b | i_data_a;
      OP_AND:  alu_res_s = i_data_b & i_data_a;
      OP_XOR:  alu_res_s = i_data_b ^ i_data_a;
      OP_SHL:  alu_res_s = (i_data_a >= SH_LIM) ? {WIDTH{1'b0}} : (i_data_b << i_data_a);
      OP_SHR:  alu_res_s = (i_data_a >= SH_LIM) ? {WIDTH{1'b0}} : (i_data_b >> i_data_a);
      default: alu_res_s = i_data_b + i_data_a;
    endcase
  end

  // Handshake FSM next state and output register loads
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    dbz_d        = dbz_q;
    dbz_pend_d   = dbz_pend_q;
    iter_start_s = 1'b0;
`ifdef Z16_ALU_REM_EN
    rem_d        = rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d = op_in_s;
          if (is_iter(op_in_s)) begin
            iter_start_s = 1'b1;
            dbz_pend_d   = (op_in_s == OP_DIV) && (i_data_a == {WIDTH{1'b0}});
            state_d      = ST_BUSY;
          end else begin
            data_d  = alu_res_s;
            dbz_d   = 1'b0;
`ifdef Z16_ALU_REM_EN
            rem_d   = {WIDTH{1'b0}};
`endif
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (iter_done_s) begin
          data_d  = iter_res_s;
          dbz_d   = dbz_pend_q;
`ifdef Z16_ALU_REM_EN
          rem_d   = (op_q == OP_DIV) ? iter_rem_s : {WIDTH{1'b0}};
`endif
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      data_q     <= {WIDTH{1'b0}};
      dbz_q      <= 1'b0;
      dbz_pend_q <= 1'b0;
`ifdef Z16_ALU_REM_EN
      rem_q      <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      dbz_q      <= dbz_d;
      dbz_pend_q <= dbz_pend_d;
`ifdef Z16_ALU_REM_EN
      rem_q      <= rem_d;
`endif
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_data  = data_q;
  assign o_dbz   = dbz_q;
`ifdef Z16_ALU_REM_EN
  assign o_rem   = rem_q;
`endif

endmodule
